// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory controller.
//   - FSM state encodings (IDLE, WAIT, DONE)
//   - default number of wait states inserted before an access completes
package dmem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_WAIT_STATES = 2;

endpackage

// File: rtl/dmem_ctrl_array.sv
// Word storage for the data-memory controller.
// One synchronous write port and one combinational read port, no reset:
// contents survive a controller reset and start undefined.
//   clk   : write clock
//   we    : write enable for this edge
//   waddr : word index to write
//   wdata : word to write
//   raddr : word index to read
//   rdata : word at raddr (combinational)
module dmem_array #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [31:0]          rdata
);

    logic [31:0] mem_r [2**ADDR_BITS];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/dmem_ctrl.sv
// Wait-state data-memory controller for the MIPS core.
// Accepts one load or store at a time, holds the CPU with stall for
// WAIT_STATES+1 cycles and completes with a one-cycle done pulse.
// Misaligned accesses and simultaneous read+write requests fault (err).
//   clk, reset        : clock and synchronous active-high reset
//   memread, memwrite : CPU request, held until done
//   addr, writedata   : byte address and store data
//   readdata          : load data in the done cycle, 0 otherwise
//   stall             : request pending and not yet done
//   done, err         : completion pulse and its fault flag
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [1:0]           state_r, state_s;
    logic [3:0]           count_r, count_s;
    logic [ADDR_BITS-1:0] idx_r, idx_s;
    logic [31:0]          wdata_r, wdata_s;
    logic                 store_r, store_s;
    logic                 load_r, load_s;
    logic                 done_r, done_s;
    logic                 err_r, err_s;
    logic [31:0]          rdata_r, rdata_s;

    logic                 req_s;
    logic                 acc_fault_s;
    logic [ADDR_BITS-1:0] addr_idx_s;
    logic [ADDR_BITS-1:0] rd_idx_s;
    logic [31:0]          rd_word_s;
    logic                 we_s;
    logic                 unused_addr_s;

    assign req_s       = memread | memwrite;
    assign addr_idx_s  = addr[ADDR_BITS+1:2];
    // Upper address bits wrap away; byte offset only feeds the fault check.
    assign unused_addr_s = ^addr[31:ADDR_BITS+2];
    assign acc_fault_s = (addr[1:0] != 2'd0) | (memread & memwrite);

    // With zero wait states the read happens in the accept cycle, before
    // the address is latched, so the read index follows the live address.
    assign rd_idx_s = (state_r == ST_IDLE) ? addr_idx_s : idx_r;

    // A reset in the DONE cycle aborts the store.
    assign we_s = (state_r == ST_DONE) & store_r & ~reset;

    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .waddr (idx_r),
        .wdata (wdata_r),
        .raddr (rd_idx_s),
        .rdata (rd_word_s)
    );

    // Next-state, latch and completion logic.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        idx_s   = idx_r;
        wdata_s = wdata_r;
        store_s = store_r;
        load_s  = load_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        rdata_s = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    idx_s   = addr_idx_s;
                    wdata_s = writedata;
                    store_s = memwrite & ~acc_fault_s;
                    load_s  = memread & ~acc_fault_s;
                    if (WAIT_STATES == 0) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        err_s   = acc_fault_s;
                        rdata_s = (memread & ~acc_fault_s) ? rd_word_s : 32'd0;
                    end else begin
                        state_s = ST_WAIT;
                        count_s = WS_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_s) begin
                    // CPU flush: abandon the access silently.
                    state_s = ST_IDLE;
                    count_s = 4'd0;
                end else if (count_r == 4'd0) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    err_s   = ~(store_r | load_r);
                    rdata_s = load_r ? rd_word_s : 32'd0;
                end else begin
                    count_s = count_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                count_s = 4'd0;
            end
            default: begin
                state_s = ST_IDLE;
                count_s = 4'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= 4'd0;
            idx_r   <= '0;
            wdata_r <= 32'd0;
            store_r <= 1'b0;
            load_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            idx_r   <= idx_s;
            wdata_r <= wdata_s;
            store_r <= store_s;
            load_r  <= load_s;
            done_r  <= done_s;
            err_r   <= err_s;
            rdata_r <= rdata_s;
        end
    end

    assign done     = done_r;
    assign err      = err_r;
    assign readdata = rdata_r;
    assign stall    = req_s & ~done_r;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: ADDR_BITS, default 8, word-address width, giving 2^ADDR_BITS 32-bit words of storage.
REQ-002 Parameter: WAIT_STATES, default 2, extra cycles inserted before completion, legal range 0..15.
REQ-003 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port: reset, input, 1, synchronous active-high reset sampled on rising clk.
REQ-005 Port: memread, input, 1, CPU load request, held until done.
REQ-006 Port: memwrite, input, 1, CPU store request, held until done.
REQ-007 Port: addr, input, 32, byte address from the CPU ALU result.
REQ-008 Port: writedata, input, 32, store data.
REQ-009 Port: readdata, output, 32, load data, valid only in the done cycle, 0 otherwise.
REQ-010 Port: stall, output, 1, combinational: (memread|memwrite) & ~done; the CPU freezes its PC and pipeline while it is high.
REQ-011 Port: done, output, 1, registered, high for exactly one cycle per completed or errored access.
REQ-012 Port: err, output, 1, high only in a done cycle whose access faulted.

Function
REQ-013 FSM states are IDLE, WAIT and DONE; the reset state is IDLE.
REQ-014 In IDLE, a request (memread or memwrite high) latches addr, writedata and the operation type.
REQ-015 On that latch, the FSM moves to WAIT with the counter loaded to WAIT_STATES-1, or directly to DONE when WAIT_STATES=0.
REQ-016 In WAIT, the counter decrements each cycle and the FSM moves to DONE on the cycle the counter reads 0.
REQ-017 In DONE, done=1 for one cycle, then the FSM returns to IDLE unconditionally.
REQ-018 A new request is accepted no earlier than the cycle after DONE.
REQ-019 Latency: request first sampled in cycle 0 gives done=1 in cycle WAIT_STATES+1, so stall is high for WAIT_STATES+1 cycles.
REQ-020 Store: the memory word at latched addr[ADDR_BITS+1:2] is written on the clock edge that ends the DONE cycle.
REQ-021 Load: readdata shows the word at the latched address during DONE, including any store completed earlier.
REQ-022 Address bits above ADDR_BITS+1 are ignored, so addresses wrap modulo 2^(ADDR_BITS+2) bytes.
REQ-023 Misaligned access (latched addr[1:0]!=0): no write, readdata=0, err=1 in DONE; latency is unchanged.
REQ-024 memread and memwrite both high at acceptance: treated as a fault with no write, readdata=0, err=1.
REQ-025 If both memread and memwrite drop while in WAIT (CPU flush), the FSM returns to IDLE next cycle with no write and no done pulse.
REQ-026 Inputs changing during WAIT or DONE are ignored; only the latched values are used.

Reset
REQ-027 Reset forces IDLE, counter=0, done=0, err=0, readdata=0, and aborts any in-flight store with no write.
REQ-028 Storage contents are not cleared by reset, and no initial contents are defined.

Structure
REQ-029 State encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and the default WAIT_STATES belong in the shared MIPS parts package/header.
REQ-030 Storage is a single sub-module, dmem_array: one synchronous-write port and one combinational-read port, with no reset.
REQ-031 The FSM, counter, latches and fault logic live in dmem_ctrl.

Verification
REQ-032 With WAIT_STATES=2: store 0xDEADBEEF at 0x10, then load 0x10 -> stall high for 3 cycles each, done in cycle 3, readdata=0xDEADBEEF.
REQ-033 With WAIT_STATES=0: load 0x10 -> stall high for 1 cycle, done in cycle 1 -> back-to-back loads of 0x10 and 0x14 complete in consecutive 2-cycle windows.
REQ-034 Store at 0x13 (misaligned) -> err=1 with done, readdata=0 -> a following load of 0x10 returns the earlier value unchanged.
REQ-035 With ADDR_BITS=8: store 0x12345678 at 0x400 -> a load of 0x000 returns 0x12345678 (wrap).
REQ-036 Store 0xA5A5A5A5 at 0x20, then assert reset in WAIT cycle 1 -> FSM is IDLE, done never pulses, and a later load of 0x20 returns the prior contents.
REQ-037 Drop memwrite in WAIT -> no done and no write -> memread and memwrite both high -> err=1, no write.
